// File: rtl/apb_cmd_arbiter_if.sv
// apb_cmd_arbiter_if
//   Bundles the requester-side command/response signals and the APB-master
//   side command/response signals of apb_cmd_arbiter.
//   Modports:
//     slave  - arbiter view (requests and master responses in, grants out)
//     master - environment view (drives requests and master responses)
//   Signals:
//     i_req_cmd   NR*CW  requester commands, slice k = {pwrite,pstrb,pwdata,paddr}
//     i_req_valid NR     per-requester command valid
//     o_req_ready NR     per-requester completion strobe
//     o_req_resp  NR*RW  per-requester response, slice k = {pslverr,prdata}
//     o_grant     NR     registered one-hot grant
//     o_busy      1      a grant is active
//     o_cmd       CW     command forwarded to the APB master
//     o_valid     1      command valid to the APB master
//     i_resp      RW     response from the APB master
//     i_ready     1      completion from the APB master
//     i_req_lock  NR     per-requester lock (only with APB_ARB_LOCK_EN)
interface apb_cmd_arbiter_if #(
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int AW = 8
);
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;
  localparam int RW = 1 + DW;

  logic [NR*CW-1:0] i_req_cmd;
  logic [NR-1:0]    i_req_valid;
  logic [NR-1:0]    o_req_ready;
  logic [NR*RW-1:0] o_req_resp;
  logic [NR-1:0]    o_grant;
  logic             o_busy;
  logic [CW-1:0]    o_cmd;
  logic             o_valid;
  logic [RW-1:0]    i_resp;
  logic             i_ready;
`ifdef APB_ARB_LOCK_EN
  logic [NR-1:0]    i_req_lock;
`endif

  modport slave (
`ifdef APB_ARB_LOCK_EN
    input  i_req_lock,
`endif
    input  i_req_cmd, i_req_valid, i_resp, i_ready,
    output o_req_ready, o_req_resp, o_grant, o_busy, o_cmd, o_valid
  );

  modport master (
`ifdef APB_ARB_LOCK_EN
    output i_req_lock,
`endif
    output i_req_cmd, i_req_valid, i_resp, i_ready,
    input  o_req_ready, o_req_resp, o_grant, o_busy, o_cmd, o_valid
  );
endinterface

// File: rtl/apb_cmd_arbiter.sv
// apb_cmd_arbiter
//   Round-robin arbiter sharing one APB master command/response channel among
//   NR requesters. One requester is granted at a time; its command is muxed to
//   the master and the master's completion/response is routed back only to it.
//   Optional feature macro: APB_ARB_LOCK_EN (adds per-requester lock and a
//   LOCKED state so a requester can keep the bus across several transfers).
//   Ports:
//     pclk     clock
//     presetn  synchronous active-low reset
//     bus      apb_cmd_arbiter_if.slave (requester side and APB-master side)
module apb_cmd_arbiter #(
  parameter int NR = 4,
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb_cmd_arbiter_if.slave      bus
);
  localparam int SW = DW / 8;
  localparam int CW = 1 + SW + DW + AW;
  localparam int RW = 1 + DW;
  localparam int LW = (NR > 1) ? $clog2(NR) : 1;
  localparam logic [NR-1:0] ONE = NR'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1
`ifdef APB_ARB_LOCK_EN
    , ST_LOCKED = 2'd2
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [NR-1:0]   grant_q, grant_d;
  logic [LW-1:0]   last_q,  last_d;

  logic [LW-1:0]   sel_idx;
  logic [LW-1:0]   cand;
  logic            found;
  logic [LW-1:0]   gidx;
  logic            drop_grant;
  logic [CW-1:0]   cmd_mux;
  logic [NR-1:0]   ready_v;
  logic [NR*RW-1:0] resp_v;

  // Round-robin pick: first valid requester after last_q, wrapping.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NR; k++) begin
      cand = LW'((int'(last_q) + k) % NR);
      if (!found && bus.i_req_valid[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Grant is one-hot, so encoding and muxing are plain OR-reductions.
  always_comb begin
    gidx    = '0;
    cmd_mux = '0;
    for (int k = 0; k < NR; k++) begin
      if (grant_q[k]) begin
        gidx    = LW'(k);
        cmd_mux = cmd_mux | bus.i_req_cmd[k*CW +: CW];
      end
    end
  end

  // Completion is only meaningful while BUSY; i_ready in other states is ignored.
  always_comb begin
    ready_v = '0;
    resp_v  = '0;
    if (state_q == ST_BUSY && bus.i_ready) begin
      ready_v = grant_q;
      for (int k = 0; k < NR; k++) begin
        if (grant_q[k]) resp_v[k*RW +: RW] = bus.i_resp;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    drop_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = ONE << sel_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.i_ready) begin
          drop_grant = 1'b1;
`ifdef APB_ARB_LOCK_EN
          if (bus.i_req_lock[gidx]) begin
            drop_grant = 1'b0;
            state_d    = ST_LOCKED;
          end
`endif
        end
      end
`ifdef APB_ARB_LOCK_EN
      ST_LOCKED: begin
        // Locked owner re-issues with the same grant; others stay blocked.
        if (bus.i_req_valid[gidx]) begin
          state_d = ST_BUSY;
        end else if (!bus.i_req_lock[gidx]) begin
          drop_grant = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    if (drop_grant) begin
      grant_d = '0;
      last_d  = gidx;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NR - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_valid     = (state_q == ST_BUSY);
  assign bus.o_cmd       = cmd_mux;
  assign bus.o_req_ready = ready_v;
  assign bus.o_req_resp  = resp_v;
endmodule

// File: doc/apb_cmd_arbiter.md
# apb_cmd_arbiter

Round-robin arbiter that shares one APB master command/response interface among NR requesters. Each requester presents a command using the same valid/ready command protocol the APB master accepts. The arbiter grants one requester at a time and forwards its command to the master. It returns the master's response only to the granted requester. It sits between CPU/DMA-side command sources and the APB master.

## Interface
Parameters:
- NR, 4, number of requesters (2..16)
- DW, 32, APB data width
- AW, 8, APB address width (max 32)
- SW, DW/8, derived strobe width
- CW, 1+SW+DW+AW, derived command width, packed {pwrite, pstrb, pwdata, paddr}
- RW, 1+DW, derived response width, packed {pslverr, prdata}

Ports:
- pclk  in  1  clock
- presetn  in  1  reset; synchronous, active-low
- i_req_cmd  in  NR*CW  requester commands; requester k occupies bits [k*CW +: CW]
- i_req_valid  in  NR  per-requester command valid
- o_req_ready  out  NR  per-requester completion strobe; one-hot or zero
- o_req_resp  out  NR*RW  per-requester response; slice k is valid only while o_req_ready[k]=1, and is zero otherwise
- o_grant  out  NR  registered one-hot grant; zero when idle
- o_busy  out  1  a grant is active
- o_cmd  out  CW  command to the APB master: the granted slice, or zero when idle
- o_valid  out  1  command valid to the APB master
- i_resp  in  RW  response from the APB master
- i_ready  in  1  completion from the APB master
- i_req_lock  in  NR  per-requester lock request; present only with APB_ARB_LOCK_EN

## Operation
- Registered state: state_ff (IDLE, BUSY, plus LOCKED with the macro), grant_ff[NR], last_ff (index of the last completed requester).
- IDLE:
  - If any i_req_valid is set, select the first set bit scanning from index last_ff+1 upward, wrapping modulo NR.
  - Load grant_ff with the selected bit and go to BUSY.
  - If no valid is set, stay in IDLE.
- BUSY:
  - o_valid=1 and o_cmd=slice[grant] (mux driven from the registered grant).
  - On i_ready=1: o_req_ready[grant]=1 and o_req_resp[grant]=i_resp, both combinational in that cycle.
  - On the same edge: last_ff←grant, grant_ff←0, state→IDLE.
- Requesters must hold valid and the command stable until their ready pulse. The arbiter does not check this. Once granted, the grant holds until i_ready, even if the requester drops valid.
- Requests arriving while BUSY wait; there is no preemption.
- i_ready seen in IDLE is ignored: no ready pulse is produced and no state changes.
- o_busy = (state_ff != IDLE).
- Reset values: state IDLE, grant_ff 0, last_ff NR-1 (requester 0 has first priority). All outputs read 0.
- Reset asserted mid-transfer drops the grant on the next edge. The APB master is expected to share presetn.

## Timing
- Cycle 0: IDLE, request sampled.
- Cycle 1: BUSY, o_valid=1.
- The APB master moves to SETUP at cycle 2 and ACCESS at cycle 3. With zero-wait pready, i_ready and o_req_ready arrive in cycle 3.
- Minimum request-to-ready latency: 3 cycles. Each slave wait state adds 1.
- One IDLE bubble follows every completion. Back-to-back grants are therefore separated by one cycle; this matches the master's own IDLE return.
- Worst-case wait for any requester: NR-1 other transfers.

## Configuration
- APB_ARB_LOCK_EN defined:
  - The i_req_lock port exists and state LOCKED is added.
  - If i_req_lock[grant]=1 at completion, go to LOCKED instead of IDLE, keeping grant_ff; last_ff is not updated.
  - In LOCKED: o_valid=0 and o_busy=1.
  - Granted requester's valid=1 → BUSY with the same grant.
  - Otherwise, i_req_lock[grant]=0 → IDLE, last_ff←grant.
  - Other requesters are blocked while LOCKED. This supports atomic read-modify-write sequences.
- APB_ARB_LOCK_EN not defined: no lock port, no LOCKED state; every completion returns to IDLE.

## Test plan
- Single requester: req1 writes paddr=0x10, pwdata=0xA5A5A5A5, zero-wait slave → o_grant=0010 at cycle 1, o_req_ready[1] at cycle 3, o_req_resp slice1 = {0, prdata}, IDLE at cycle 4.
- All four valid from reset → grant order 0,1,2,3,0; each completion is followed by exactly one IDLE cycle.
- Requesters 2 and 3 requesting after requester 3 completes → requester 0 absent, so 2 is served before 3 (wrap-around pointer).
- Slave inserts 2 wait states with pslverr=1 on req0's read → o_req_ready[0] at cycle 5, resp MSB=1; other ready bits stay 0 throughout.
- presetn asserted while BUSY → next cycle: o_grant=0, o_valid=0, o_busy=0; the next grant goes to req0.
- With APB_ARB_LOCK_EN, req2 locks for two transfers while req0 is pending → req2, req2, then req0; o_valid=0 during LOCKED cycles.
